// File: rtl/reg_snapshot_ctrl.sv
// Branch checkpoint FIFO with a mispredict restore handshake toward the register file.
// Optional SNAP_WB_FORWARD_EN folds same-cycle write-back data into each captured image.
module reg_snapshot_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         take_snapshot,
    input  logic [31:0][31:0]            regs_in,
    input  logic                         wb_uses_rw,
    input  logic [4:0]                   wb_rw_addr,
    input  logic [31:0]                  wb_rw_data,
    input  logic                         resolve_valid,
    input  logic                         resolve_mispredict,
    input  logic                         recovery_done,
    output logic                         recover_snapshot,
    output logic [31:0][31:0]            regs_snapshot,
    output logic                         recovery_done_ack,
    output logic                         busy,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        ACK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0][31:0] r_mem [DEPTH];
    logic [31:0][31:0] r_snap;
    logic [31:0][31:0] w_image;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_recover;
    logic             r_ack;
    logic             r_busy;
    logic             w_flush;
    logic             w_pop;
    logic             w_push;

    assign full              = (r_count == CW'(DEPTH));
    assign empty             = (r_count == '0);
    assign count             = r_count;
    assign busy              = r_busy;
    assign recover_snapshot  = r_recover;
    assign recovery_done_ack = r_ack;
    assign regs_snapshot     = r_snap;

    // A flush wins over a same-cycle push; a full FIFO can still push if it also pops.
    assign w_flush = resolve_valid && resolve_mispredict && !empty && !r_busy;
    assign w_pop   = resolve_valid && !resolve_mispredict && !empty && !r_busy;
    assign w_push  = take_snapshot && !r_busy && !w_flush && (!full || w_pop);

`ifdef SNAP_WB_FORWARD_EN
    always_comb begin
        w_image = regs_in;
        if (wb_uses_rw) begin
            w_image[wb_rw_addr] = wb_rw_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{wb_uses_rw, wb_rw_addr, wb_rw_data};
    assign w_image  = regs_in;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_flush)        w_next = RECOVER;
            RECOVER: if (recovery_done)  w_next = ACK;
            ACK:     if (!recovery_done) w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_recover <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_recover <= (w_next == RECOVER);
            r_ack     <= (w_next == ACK);
            r_busy    <= (w_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_flush) begin
            r_snap <= r_mem[r_head];
        end
    end

    // Checkpoint storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_tail] <= w_image;
        end
    end

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Bench for reg_snapshot_ctrl: directed scenarios then random traffic vs a queue model.
// Define SNAP_WB_FORWARD_EN for both bench and design to cover write-back forwarding.
module tb_reg_snapshot_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [31:0][31:0] img_t;

    logic          clk;
    logic          rst_n;
    logic          take_snapshot;
    img_t          regs_in;
    logic          wb_uses_rw;
    logic [4:0]    wb_rw_addr;
    logic [31:0]   wb_rw_data;
    logic          resolve_valid;
    logic          resolve_mispredict;
    logic          recovery_done;
    logic          recover_snapshot;
    img_t          regs_snapshot;
    logic          recovery_done_ack;
    logic          busy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    int n_cmp;
    int n_err;

    img_t mq[$];
    img_t msnap;
    bit   mbusy;
    bit   mrec;
    bit   mack;
    img_t imgs [6];

    reg_snapshot_ctrl #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .take_snapshot      (take_snapshot),
        .regs_in            (regs_in),
        .wb_uses_rw         (wb_uses_rw),
        .wb_rw_addr         (wb_rw_addr),
        .wb_rw_data         (wb_rw_data),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .recovery_done      (recovery_done),
        .recover_snapshot   (recover_snapshot),
        .regs_snapshot      (regs_snapshot),
        .recovery_done_ack  (recovery_done_ack),
        .busy               (busy),
        .full               (full),
        .empty              (empty),
        .count              (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic img_t rand_img();
        img_t t;
        for (int i = 0; i < 32; i++) t[i] = $urandom;
        return t;
    endfunction

    function automatic img_t captured();
        img_t t;
        t = regs_in;
`ifdef SNAP_WB_FORWARD_EN
        if (wb_uses_rw) t[wb_rw_addr] = wb_rw_data;
`endif
        return t;
    endfunction

    // Reference behaviour: a queue of checkpoints plus the restore handshake phase.
    task automatic model_step();
        img_t img;
        bit   pop;
        img = captured();
        if (!rst_n) begin
            mq.delete();
            msnap = '0;
            mbusy = 0;
            mrec  = 0;
            mack  = 0;
        end else if (mrec) begin
            if (recovery_done) begin
                mrec = 0;
                mack = 1;
            end
        end else if (mack) begin
            if (!recovery_done) begin
                mack  = 0;
                mbusy = 0;
            end
        end else if (resolve_valid && resolve_mispredict && mq.size() > 0) begin
            msnap = mq[0];
            mq.delete();
            mrec  = 1;
            mbusy = 1;
        end else begin
            pop = resolve_valid && !resolve_mispredict && mq.size() > 0;
            if (pop) void'(mq.pop_front());
            if (take_snapshot && mq.size() < DEPTH) mq.push_back(img);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic chk_snap(string tag, img_t obs, img_t exp);
        int k;
        k = 0;
        for (int i = 31; i >= 0; i--) if (obs[i] !== exp[i]) k = i;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: reg %0d got %h exp %h", tag, k, obs[k], exp[k]);
        end
    endtask

    task automatic check_all();
        chk32("count", 32'(count), 32'(mq.size()));
        chk32("full", 32'(full), 32'(mq.size() == DEPTH));
        chk32("empty", 32'(empty), 32'(mq.size() == 0));
        chk32("busy", 32'(busy), 32'(mbusy));
        chk32("recover", 32'(recover_snapshot), 32'(mrec));
        chk32("ack", 32'(recovery_done_ack), 32'(mack));
        chk_snap("snapshot", regs_snapshot, msnap);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        take_snapshot      = 0;
        wb_uses_rw         = 0;
        wb_rw_addr         = '0;
        wb_rw_data         = '0;
        resolve_valid      = 0;
        resolve_mispredict = 0;
        recovery_done      = 0;
    endtask

    task automatic handshake();
        resolve_valid = 0;
        recovery_done = 1;
        cycle();
        recovery_done = 0;
        cycle();
    endtask

    initial begin
        img_t t;
        logic [31:0] exp38;
        n_cmp = 0;
        n_err = 0;
        mbusy = 0;
        mrec  = 0;
        mack  = 0;
        msnap = '0;
        idle_inputs();
        regs_in = '0;
        rst_n   = 0;
        cycle();
        cycle();
        chk32("reset_count", 32'(count), 32'd0);
        chk32("reset_empty", 32'(empty), 32'd1);
        rst_n = 1;
        cycle();

        // Fill to DEPTH, then one more push must drop.
        take_snapshot = 1;
        for (int i = 0; i < 5; i++) begin
            imgs[i] = rand_img();
            regs_in = imgs[i];
            cycle();
        end
        take_snapshot = 0;
        chk32("fill_count", 32'(count), 32'd4);
        chk32("fill_full", 32'(full), 32'd1);

        // Full with push and correct resolve together.
        imgs[5]       = rand_img();
        regs_in       = imgs[5];
        take_snapshot = 1;
        resolve_valid = 1;
        cycle();
        take_snapshot = 0;
        chk32("pushpop_count", 32'(count), 32'd4);
        resolve_mispredict = 1;
        cycle();
        resolve_mispredict = 0;
        chk_snap("pushpop_head", regs_snapshot, imgs[1]);
        handshake();

        // Basic restore handshake.
        t             = rand_img();
        t[5]          = 32'h11;
        regs_in       = t;
        take_snapshot = 1;
        cycle();
        take_snapshot      = 0;
        resolve_valid      = 1;
        resolve_mispredict = 1;
        cycle();
        resolve_valid      = 0;
        resolve_mispredict = 0;
        chk32("rec_req", 32'(recover_snapshot), 32'd1);
        chk32("rec_r5", regs_snapshot[5], 32'h11);
        chk32("rec_count", 32'(count), 32'd0);
        recovery_done = 1;
        cycle();
        chk32("rec_ack", 32'(recovery_done_ack), 32'd1);
        chk32("rec_ack_req", 32'(recover_snapshot), 32'd0);
        recovery_done = 0;
        cycle();
        chk32("rec_idle_busy", 32'(busy), 32'd0);

        // Write-back in the capture cycle.
        t             = rand_img();
        t[3]          = 32'hAA;
        regs_in       = t;
        take_snapshot = 1;
        wb_uses_rw    = 1;
        wb_rw_addr    = 5'd3;
        wb_rw_data    = 32'hBB;
        cycle();
        idle_inputs();
        resolve_valid      = 1;
        resolve_mispredict = 1;
        cycle();
        resolve_mispredict = 0;
`ifdef SNAP_WB_FORWARD_EN
        exp38 = 32'hBB;
`else
        exp38 = 32'hAA;
`endif
        chk32("wb_r3", regs_snapshot[3], exp38);
        handshake();

        // Mispredict on empty is ignored; pushes during busy are dropped.
        resolve_valid      = 1;
        resolve_mispredict = 1;
        cycle();
        chk32("empty_mis_req", 32'(recover_snapshot), 32'd0);
        chk32("empty_mis_busy", 32'(busy), 32'd0);
        resolve_valid = 0;
        regs_in       = rand_img();
        take_snapshot = 1;
        cycle();
        resolve_valid = 1;
        cycle();
        resolve_valid = 0;
        cycle();
        recovery_done = 1;
        cycle();
        recovery_done = 0;
        cycle();
        take_snapshot = 0;
        cycle();
        chk32("busy_push_count", 32'(count), 32'd0);

        // Reset while restoring.
        take_snapshot = 1;
        cycle();
        take_snapshot      = 0;
        resolve_valid      = 1;
        resolve_mispredict = 1;
        cycle();
        idle_inputs();
        chk32("pre_rst_req", 32'(recover_snapshot), 32'd1);
        rst_n = 0;
        cycle();
        chk32("rst_req", 32'(recover_snapshot), 32'd0);
        chk32("rst_busy", 32'(busy), 32'd0);
        chk32("rst_count", 32'(count), 32'd0);
        rst_n = 1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n              = ($urandom_range(0, 79) != 0);
            take_snapshot      = ($urandom_range(0, 1) != 0);
            regs_in            = rand_img();
            wb_uses_rw         = ($urandom_range(0, 1) != 0);
            wb_rw_addr         = 5'($urandom);
            wb_rw_data         = $urandom;
            resolve_valid      = ($urandom_range(0, 2) == 0);
            resolve_mispredict = ($urandom_range(0, 3) == 0);
            recovery_done      = ($urandom_range(0, 1) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_snapshot_ctrl.md
REG_SNAPSHOT_CTRL -- requirements
Module: reg_snapshot_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, number of checkpoint slots (power of two, >=2).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 take_snapshot  in  1  branch predicted this cycle; capture a checkpoint.
REQ-005 regs_in  in  32x32  architectural register contents from register file (regs_out).
REQ-006 wb_uses_rw  in  1  write-back writes a register this cycle.
REQ-007 wb_rw_addr  in  5  write-back destination register.
REQ-008 wb_rw_data  in  32  write-back data.
REQ-009 resolve_valid  in  1  oldest outstanding branch resolved this cycle.
REQ-010 resolve_mispredict  in  1  qualifies resolve_valid; 1 = mispredicted.
REQ-011 recovery_done  in  1  register file "done" (restore complete).
REQ-012 recover_snapshot  out  1  level request to register file to load regs_snapshot.
REQ-013 regs_snapshot  out  32x32  checkpoint being restored; registered.
REQ-014 recovery_done_ack  out  1  acknowledge of recovery_done.
REQ-015 busy  out  1  recovery in progress; front end stalls.
REQ-016 full  out  1  count == DEPTH.
REQ-017 empty  out  1  count == 0.
REQ-018 count  out  $clog2(DEPTH+1)  occupied slots.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH 32x32 entries with head/tail pointers wrapping modulo DEPTH; branches resolve in order, so resolution always refers to the head.
REQ-020 Push: take_snapshot && !busy && (!full || pop this cycle) SHALL write the captured image at tail, tail+1; otherwise take_snapshot is dropped with no state change.
REQ-021 Correct resolve: resolve_valid && !resolve_mispredict && !empty && !busy SHALL advance head by 1 (pop); when empty it is ignored.
REQ-022 Simultaneous push and correct pop SHALL leave count unchanged, including when full.
REQ-023 FSM states IDLE, RECOVER, ACK; IDLE->RECOVER on resolve_valid && resolve_mispredict && !empty && !busy.
REQ-024 On IDLE->RECOVER edge: regs_snapshot <= head entry, all entries flushed (head=tail, count=0); a take_snapshot in the same cycle SHALL be discarded.
REQ-025 RECOVER: recover_snapshot=1, busy=1; on recovery_done==1 go to ACK.
REQ-026 ACK: recover_snapshot=0, recovery_done_ack=1, busy=1; on recovery_done==0 go to IDLE.
REQ-027 Outputs recover_snapshot, recovery_done_ack, busy SHALL be registered (asserted the cycle after the triggering edge).
REQ-028 Mispredict with empty SHALL be ignored (no recovery).
REQ-029 While busy, take_snapshot and resolve_valid SHALL be ignored.
REQ-030 full, empty, count SHALL be derived combinationally from the registered count.

Reset
REQ-031 On posedge clk with rst_n==0: state=IDLE, head=tail=0, count=0, recover_snapshot=0, recovery_done_ack=0, busy=0, regs_snapshot=all zero; storage contents not reset.
REQ-032 Reset during RECOVER or ACK SHALL abort recovery and return to IDLE with all outputs at reset values next cycle.

Configuration
REQ-033 Macro SNAP_WB_FORWARD_EN defined: the captured image SHALL equal regs_in with entry wb_rw_addr replaced by wb_rw_data when wb_uses_rw is 1 in the push cycle (any address).
REQ-034 SNAP_WB_FORWARD_EN undefined: regs_in SHALL be captured verbatim; wb_* inputs unused.

Verification
REQ-035 Reset then 4 pushes (DEPTH=4) -> count=4, full=1; 5th push dropped, count stays 4.
REQ-036 Full, push + correct resolve same cycle -> count=4, oldest entry popped, new image at tail.
REQ-037 Push with regs_in[5]=0x11, then mispredict -> recover_snapshot=1 next cycle, regs_snapshot[5]=0x11, count=0; done=1 -> ACK with recovery_done_ack=1; done=0 -> IDLE, busy=0.
REQ-038 Push with regs_in[3]=0xAA, wb_uses_rw=1, wb_rw_addr=3, wb_rw_data=0xBB, then mispredict -> regs_snapshot[3]=0xBB with SNAP_WB_FORWARD_EN, 0xAA without.
REQ-039 Mispredict when empty -> no recover_snapshot; take_snapshot during busy -> count stays 0 after recovery.
REQ-040 rst_n=0 during RECOVER -> next cycle recover_snapshot=0, busy=0, count=0, state IDLE.
